// File: rtl/simon_pkg.sv
// Purpose : shared types and helpers for the Simon sequence player.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: FSM state enum, colour constants, colour -> one-hot LED encoder.
package simon_pkg;

  typedef enum logic [3:0] {
    IDLE,
    P_RERUN,
    P_FETCH0,
    P_FETCH1,
    SHOW_ON,
    SHOW_OFF,
    C_RERUN,
    C_FETCH0,
    C_FETCH1,
    WAIT_BTN,
    PASS,
    FAIL
  } state_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] BLUE   = 2'd2;
  localparam logic [1:0] YELLOW = 2'd3;

  // Colour c lights LED bit c; the same encoding is the expected button.
  function automatic logic [3:0] colour_led(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_interval_timer.sv
// Purpose : loadable down-counter used for LED on/off times and press timeout.
// Latency : load takes effect next cycle; expired is combinational from the count.
// Backpressure: none; count only decrements while count=1 and the value is non-zero.
// Ports: clk, reset (async active-low), load/load_val (load wins over count),
//        count (decrement enable), expired (count has reached zero).
module simon_interval_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Loading N-1 makes a state that waits for expired last exactly N cycles.
  assign expired = (cnt == '0);

endmodule

// File: rtl/simon_sequence_player.sv
// Purpose : replays the LFSR colour pattern on the LEDs, then checks button presses against it.
// Latency : start -> rerun next cycle; final correct press -> pass next cycle, idle the cycle after.
// Backpressure: none; start is ignored while busy, btn is ignored outside WAIT_BTN.
// Ports: clk, reset (async active-low), start/level (round request, length),
//        random/step/rerun (LFSR interface), btn/led (player I/O), busy/pass/fail (status).
module simon_sequence_player
  import simon_pkg::*;
#(
  parameter int MAX_LEN        = 31,
  parameter int ON_CYCLES      = 12_500_000,
  parameter int OFF_CYCLES     = 6_250_000,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] level,
  input  logic       random,
  output logic       step,
  output logic       rerun,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic       busy,
  output logic       pass,
  output logic       fail
);

  localparam int MAX_OF_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_CYC = (MAX_OF_ON_OFF > TIMEOUT_CYCLES) ? MAX_OF_ON_OFF : TIMEOUT_CYCLES;
  localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);

  state_t      state;
  logic [4:0]  idx;
  logic [4:0]  len;
  logic [1:0]  colour;

  logic [4:0]  len_in;
  logic [5:0]  idx_nxt;
  logic        last_elem;

  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_count;
  logic          t_exp;

  // Length is clamped to 1..MAX_LEN when the round is accepted.
  always_comb begin
    len_in = level;
    if (level == 5'd0) begin
      len_in = 5'd1;
    end else if (level > LEN_MAX) begin
      len_in = LEN_MAX;
    end
  end

  assign idx_nxt   = {1'b0, idx} + 6'd1;
  assign last_elem = (idx_nxt >= {1'b0, len});

  // Timer is loaded one cycle before the timed state so that state lasts
  // exactly the programmed number of cycles.
  always_comb begin
    t_load  = 1'b0;
    t_val   = ON_LOAD;
    t_count = 1'b0;
    case (state)
      P_FETCH1: t_load = 1'b1;
      SHOW_ON: begin
        if (t_exp) begin
          t_load = 1'b1;
          t_val  = OFF_LOAD;
        end else begin
          t_count = 1'b1;
        end
      end
      SHOW_OFF: t_count = 1'b1;
      C_FETCH1: begin
        t_load = 1'b1;
        t_val  = TO_LOAD;
      end
      WAIT_BTN: t_count = 1'b1;
      default: ;
    endcase
  end

  simon_interval_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .count    (t_count),
    .expired  (t_exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      len    <= '0;
      colour <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len   <= len_in;
            idx   <= '0;
            state <= P_RERUN;
          end
        end
        P_RERUN: state <= P_FETCH0;
        // random shows the pre-shift LFSR bit while step is high.
        P_FETCH0: begin
          colour[1] <= random;
          state     <= P_FETCH1;
        end
        P_FETCH1: begin
          colour[0] <= random;
          state     <= SHOW_ON;
        end
        SHOW_ON: begin
          if (t_exp) state <= SHOW_OFF;
        end
        SHOW_OFF: begin
          if (t_exp) begin
            if (last_elem) begin
              idx   <= '0;
              state <= C_RERUN;
            end else begin
              idx   <= idx_nxt[4:0];
              state <= P_FETCH0;
            end
          end
        end
        C_RERUN: state <= C_FETCH0;
        C_FETCH0: begin
          colour[1] <= random;
          state     <= C_FETCH1;
        end
        C_FETCH1: begin
          colour[0] <= random;
          state     <= WAIT_BTN;
        end
        WAIT_BTN: begin
          if (btn == 4'b0000) begin
            if (t_exp) state <= FAIL;
          end else if (btn == colour_led(colour)) begin
            if (last_elem) begin
              state <= PASS;
            end else begin
              idx   <= idx_nxt[4:0];
              state <= C_FETCH0;
            end
          end else begin
            state <= FAIL;
          end
        end
        PASS:    state <= IDLE;
        FAIL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign rerun = (state == P_RERUN) || (state == C_RERUN);
  assign step  = (state == P_FETCH0) || (state == P_FETCH1) ||
                 (state == C_FETCH0) || (state == C_FETCH1);
  assign led   = (state == SHOW_ON) ? colour_led(colour) : 4'b0000;
  assign pass  = (state == PASS);
  assign fail  = (state == FAIL);

endmodule

// File: tb/tb_simon_sequence_player.sv
// Purpose : directed bench for simon_sequence_player with a behavioural LFSR source.
// Latency : n/a.
// Backpressure: n/a.
module tb_simon_sequence_player;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] level;
  logic       random;
  logic       step;
  logic       rerun;
  logic [3:0] btn;
  logic [3:0] led;
  logic       busy;
  logic       pass;
  logic       fail;

  int total = 0;
  int bad   = 0;

  int rerun_cnt = 0;
  int step_cnt  = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic [15:0] lfsr;

  always #5 clk = ~clk;

  simon_sequence_player #(
    .MAX_LEN        (8),
    .ON_CYCLES      (4),
    .OFF_CYCLES     (2),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset  (rst_n),
    .start  (start),
    .level  (level),
    .random (random),
    .step   (step),
    .rerun  (rerun),
    .btn    (btn),
    .led    (led),
    .busy   (busy),
    .pass   (pass),
    .fail   (fail)
  );

  function automatic logic [15:0] lfsr_shift(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // Behavioural LFSR: output is the LSB, shifted right on each step.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lfsr <= SEED;
    else if (rerun) lfsr <= SEED;
    else if (step)  lfsr <= lfsr_shift(lfsr);
  end
  assign random = lfsr[0];

  always @(posedge clk) begin
    if (rerun) rerun_cnt <= rerun_cnt + 1;
    if (step)  step_cnt  <= step_cnt + 1;
    if (pass)  pass_cnt  <= pass_cnt + 1;
    if (fail)  fail_cnt  <= fail_cnt + 1;
  end

  // Colour i of the pattern: two consecutive LFSR bits, first one is the MSB.
  function automatic logic [1:0] exp_col(input int i);
    logic [15:0] s;
    logic [1:0]  c;
    s = SEED;
    for (int k = 0; k < 2 * i; k++) s = lfsr_shift(s);
    c[1] = s[0];
    s = lfsr_shift(s);
    c[0] = s[0];
    return c;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_led"},   {28'd0, led}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_step"},  {31'd0, step}, 32'd0);
    check({tag, "_rerun"}, {31'd0, rerun}, 32'd0);
    check({tag, "_pass"},  {31'd0, pass}, 32'd0);
    check({tag, "_fail"},  {31'd0, fail}, 32'd0);
  endtask

  // bad_at < 0: every press correct. bad_btn == 0 at bad_at: no press (timeout).
  task automatic run_round(input logic [4:0] lvl, input int n, input int bad_at,
                           input logic [3:0] bad_btn, input bit noise);
    int r0, s0, p0, f0, w, on, exp_steps;
    bit extra;
    r0 = rerun_cnt; s0 = step_cnt; p0 = pass_cnt; f0 = fail_cnt;
    level = lvl;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy",  {31'd0, busy}, 32'd1);
    check("t1_rerun", {31'd0, rerun}, 32'd1);
    check("t1_step",  {31'd0, step}, 32'd0);
    tick();
    check("t2_step",  {31'd0, step}, 32'd1);
    check("t2_rerun", {31'd0, rerun}, 32'd0);
    tick();
    check("t3_step",  {31'd0, step}, 32'd1);
    tick();
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (led == 4'b0000 && w < 20) begin
        tick();
        w++;
      end
      check("flash_wait", {31'd0, (led != 4'b0000)}, 32'd1);
      check("flash_col", {28'd0, led}, {28'd0, onehot(exp_col(i))});
      if (i == 0) check("first_col", {28'd0, led}, 32'h4);
      on = 0;
      while (led != 4'b0000 && on < 20) begin
        if (noise) begin
          start = on[0];
          btn   = on[0] ? 4'b0001 : 4'b1000;
        end
        tick();
        on++;
      end
      start = 1'b0;
      btn   = 4'b0000;
      check("flash_len", on, 32'd4);
    end
    extra = 1'b0;
    w = 0;
    while (!rerun && w < 20) begin
      if (led != 4'b0000) extra = 1'b1;
      tick();
      w++;
    end
    check("check_rerun", {31'd0, rerun}, 32'd1);
    check("extra_flash", {31'd0, extra}, 32'd0);
    tick(); tick(); tick();
    for (int i = 0; i < n; i++) begin
      check("wait_led", {28'd0, led}, 32'd0);
      if (i == bad_at && bad_btn == 4'b0000) begin
        w = 0;
        while (!fail && w < 30) begin
          tick();
          w++;
        end
        check("timeout_len", w, 32'd10);
        tick();
        check("to_busy", {31'd0, busy}, 32'd0);
        break;
      end
      btn = (i == bad_at) ? bad_btn : onehot(exp_col(i));
      tick();
      btn = 4'b0000;
      if (i == bad_at) begin
        check("bad_fail", {31'd0, fail}, 32'd1);
        check("bad_pass", {31'd0, pass}, 32'd0);
        tick();
        check("bad_busy", {31'd0, busy}, 32'd0);
        check("bad_fail_len", {31'd0, fail}, 32'd0);
        break;
      end else if (i == n - 1) begin
        check("ok_pass", {31'd0, pass}, 32'd1);
        check("ok_fail", {31'd0, fail}, 32'd0);
        tick();
        check("ok_busy", {31'd0, busy}, 32'd0);
        check("ok_pass_len", {31'd0, pass}, 32'd0);
      end else begin
        check("next_fetch", {31'd0, step}, 32'd1);
        tick(); tick();
      end
    end
    exp_steps = 2 * n + 2 * ((bad_at < 0) ? n : bad_at + 1);
    check("rerun_count", rerun_cnt - r0, 32'd2);
    check("step_count", step_cnt - s0, exp_steps);
    check("pass_count", pass_cnt - p0, (bad_at < 0) ? 32'd1 : 32'd0);
    check("fail_count", fail_cnt - f0, (bad_at < 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    int w, p0, f0;
    rst_n = 1'b0;
    start = 1'b0;
    level = 5'd0;
    btn   = 4'b0000;
    tick(); tick();
    check_quiet("reset");
    rst_n = 1'b1;
    tick();

    run_round(5'd1, 1, -1, 4'b0000, 1'b0);   // single element, correct press
    run_round(5'd3, 3, -1, 4'b0000, 1'b0);   // three elements, all correct
    run_round(5'd2, 2, 0, 4'b0001, 1'b0);    // wrong colour on first press
    run_round(5'd2, 2, 1, 4'b0000, 1'b0);    // timeout on second press
    run_round(5'd1, 1, 0, 4'b0110, 1'b0);    // two buttons at once
    run_round(5'd3, 3, -1, 4'b0000, 1'b1);   // start/btn noise during playback
    run_round(5'd0, 1, -1, 4'b0000, 1'b0);   // level 0 plays one element
    run_round(5'd31, 8, -1, 4'b0000, 1'b0);  // clamped to MAX_LEN

    // Reset while an LED is lit: everything drops immediately, no result pulse.
    p0 = pass_cnt; f0 = fail_cnt;
    level = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (led == 4'b0000 && w < 20) begin
      tick();
      w++;
    end
    check("mid_led_on", {31'd0, (led != 4'b0000)}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_no_pass", pass_cnt - p0, 32'd0);
    check("mid_no_fail", fail_cnt - f0, 32'd0);
    run_round(5'd2, 2, -1, 4'b0000, 1'b0);   // replays from the seed

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
